// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: 8-bit PC, combinational imem, QDEPTH-entry prefetch queue, head latency 1 cycle; stalls when full.
// Optional odd-redirect rejection with sticky align_fault under `IFETCH_ALIGN_CHECK_EN.
module ifetch_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] END_PC   = 8'h82,
  parameter int         QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  imem_pc,
  input  logic [15:0] imem_inst,
  output logic        out_valid,
  output logic [15:0] out_inst,
  output logic [7:0]  out_pc,
  input  logic        out_ready,
  output logic        busy,
  output logic        halted
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        align_fault
`endif
);

  localparam int         PW    = (QDEPTH == 4) ? 2 : 1;
  localparam logic [2:0] QFULL = 3'(QDEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t         state_q, state_d;
  logic [7:0]     pc_q, pc_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [15:0]    qi_q [QDEPTH];
  logic [7:0]     qp_q [QDEPTH];
  logic           vld_q, busy_q, halted_q;
  logic [15:0]    oinst_q;
  logic [7:0]     opc_q;
  logic           push, pop, flush, bad_redir;
  logic [7:0]     redir_tgt;
  logic [15:0]    head_inst;
  logic [7:0]     head_pc;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign bad_redir = redirect_valid & redirect_pc[0];
  assign redir_tgt = redirect_pc;
`else
  assign bad_redir = 1'b0;
  assign redir_tgt = redirect_pc & 8'hFE;
`endif

  assign pop = vld_q & out_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bad_redir) begin
          state_d = HALT;
        end else begin
          if (redirect_valid) pc_d = redir_tgt;
          if (start) state_d = RUN;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          // Redirect beats everything: flush, no push; the head may still pop this cycle.
          flush = 1'b1;
          if (bad_redir) begin
            state_d = HALT;
          end else begin
            pc_d = redir_tgt;
            if (halt_req) state_d = HALT;
          end
        end else begin
          push = (cnt_q < QFULL) || pop;
          if (push) pc_d = pc_q + 8'd2;
          if (halt_req || (push && pc_q == END_PC)) state_d = HALT;
        end
      end
      HALT: begin
        if (start && cnt_q == 3'd0) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (flush) begin
      cnt_d = 3'd0;
      rd_d  = '0;
      wr_d  = '0;
    end else begin
      cnt_d = cnt_q + 3'(push) - 3'(pop);
      rd_d  = rd_q + PW'(pop);
      wr_d  = wr_q + PW'(push);
    end
    // Into an empty queue the pushed word becomes the new head directly.
    if (push && wr_q == rd_d) begin
      head_inst = imem_inst;
      head_pc   = pc_q;
    end else begin
      head_inst = qi_q[rd_d];
      head_pc   = qp_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qi_q[wr_q] <= imem_inst;
      qp_q[wr_q] <= pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      cnt_q    <= 3'd0;
      rd_q     <= '0;
      wr_q     <= '0;
      vld_q    <= 1'b0;
      oinst_q  <= 16'h0000;
      opc_q    <= 8'h00;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      vld_q    <= (cnt_d != 3'd0);
      if (cnt_d != 3'd0) begin
        oinst_q <= head_inst;
        opc_q   <= head_pc;
      end
      busy_q   <= (state_d == RUN);
      halted_q <= (state_d == HALT);
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q, fault_set, fault_clr;

  assign fault_set = bad_redir && (state_q == IDLE || state_q == RUN);
  assign fault_clr = start && (state_q == IDLE || (state_q == HALT && cnt_q == 3'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
    else if (fault_clr) fault_q <= 1'b0;
  end

  assign align_fault = fault_q;
`endif

  assign imem_pc   = pc_q;
  assign out_valid = vld_q;
  assign out_inst  = oinst_q;
  assign out_pc    = opc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: default instance plus a wrap-around instance (RESET_PC=FC, END_PC=02, QDEPTH=4).
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, halt_req = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [7:0]  imem_pc, out_pc, nxt_pc;
  logic [15:0] imem_inst, out_inst;
  logic        out_valid, busy, halted;

  logic        w_start = 1'b0, w_out_ready = 1'b1;
  logic        w_halt_req = 1'b0, w_redirect_valid = 1'b0;
  logic [7:0]  w_redirect_pc = 8'h00;
  logic [7:0]  w_imem_pc, w_out_pc, w_nxt_pc;
  logic [15:0] w_imem_inst, w_out_inst;
  logic        w_out_valid, w_busy, w_halted;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        align_fault, w_align_fault;
`endif

  logic [7:0]  mem [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign nxt_pc      = imem_pc + 8'd1;
  assign imem_inst   = {mem[imem_pc], mem[nxt_pc]};
  assign w_nxt_pc    = w_imem_pc + 8'd1;
  assign w_imem_inst = {mem[w_imem_pc], mem[w_nxt_pc]};

  ifetch_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(imem_pc), .imem_inst(imem_inst),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
    .busy(busy), .halted(halted)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .align_fault(align_fault)
`endif
  );

  ifetch_ctrl #(.RESET_PC(8'hFC), .END_PC(8'h02), .QDEPTH(4)) u_wrap (
    .clk(clk), .rst(rst), .start(w_start), .halt_req(w_halt_req),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .imem_pc(w_imem_pc), .imem_inst(w_imem_inst),
    .out_valid(w_out_valid), .out_inst(w_out_inst), .out_pc(w_out_pc), .out_ready(w_out_ready),
    .busy(w_busy), .halted(w_halted)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .align_fault(w_align_fault)
`endif
  );

  // Program image: even byte = addr/2, odd byte = 0, except the two patched bytes.
  function automatic logic [15:0] exp_inst(input logic [7:0] pc);
    logic [7:0] lo;
    lo = (pc == 8'h06) ? 8'h70 : (pc == 8'h40) ? 8'h11 : 8'h00;
    return {1'b0, pc[7:1], lo};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_pc;
    int         n;
    logic       done;

    for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 1) ? 8'h00 : 8'(i / 2);
    mem[8'h07] = 8'h70;
    mem[8'h41] = 8'h11;

    // Reset state
    #12;
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_pc", {8'd0, out_pc}, 16'h0000);
    chk("rst_inst", out_inst, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_imem", {8'd0, imem_pc}, 16'h0000);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("rst_fault", {15'd0, align_fault}, 16'd0);
`endif
    rst = 1'b0;

    // Full program run to END_PC
    start = 1'b1; out_ready = 1'b1;
    step;
    start = 1'b0;
    chk("t1_busy", {15'd0, busy}, 16'd1);
    chk("t1_imem0", {8'd0, imem_pc}, 16'h0000);
    chk("t1_valid0", {15'd0, out_valid}, 16'd0);
    exp_pc = 8'h00; n = 0; done = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (out_valid) begin
        chk("t1_pc", {8'd0, out_pc}, {8'd0, exp_pc});
        chk("t1_inst", out_inst, exp_inst(exp_pc));
        exp_pc = exp_pc + 8'd2;
        n++;
      end
      if (halted && !out_valid) begin
        done = 1'b1;
        break;
      end
      step;
    end
    chk("t1_done", {15'd0, done}, 16'd1);
    chk("t1_count", 16'(n), 16'd66);
    chk("t1_hold_pc", {8'd0, out_pc}, 16'h0082);
    chk("t1_imem_end", {8'd0, imem_pc}, 16'h0084);
    chk("t1_busy_end", {15'd0, busy}, 16'd0);
    step; step; step;
    chk("t1_no_84", {15'd0, out_valid}, 16'd0);

    // Backpressure: restart from HALT with decode stalled
    out_ready = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    chk("t2_busy", {15'd0, busy}, 16'd1);
    chk("t2_halted", {15'd0, halted}, 16'd0);
    chk("t2_restart_pc", {8'd0, imem_pc}, 16'h0000);
    step; step; step;
    chk("t2_valid", {15'd0, out_valid}, 16'd1);
    chk("t2_head", {8'd0, out_pc}, 16'h0000);
    chk("t2_head_inst", out_inst, 16'h0000);
    chk("t2_stall_pc", {8'd0, imem_pc}, 16'h0004);
    out_ready = 1'b1;
    step;
    chk("t2_rel1", {8'd0, out_pc}, 16'h0002);
    chk("t2_rel1_v", {15'd0, out_valid}, 16'd1);
    step;
    chk("t2_rel2", {8'd0, out_pc}, 16'h0004);
    chk("t2_rel2_inst", out_inst, 16'h0200);
    out_ready = 1'b0;

    // Redirect with a full queue
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    step;
    redirect_valid = 1'b0;
    chk("t3_flush", {15'd0, out_valid}, 16'd0);
    chk("t3_imem", {8'd0, imem_pc}, 16'h0040);
    chk("t3_hold_pc", {8'd0, out_pc}, 16'h0004);
    chk("t3_busy", {15'd0, busy}, 16'd1);
    step;
    chk("t3_first_v", {15'd0, out_valid}, 16'd1);
    chk("t3_first_pc", {8'd0, out_pc}, 16'h0040);
    chk("t3_first_inst", out_inst, 16'h2011);
    step; step;
    chk("t3_stall", {8'd0, imem_pc}, 16'h0044);

    // halt_req with two entries queued, then drain and restart
    halt_req = 1'b1;
    step;
    halt_req = 1'b0;
    chk("t5_halted", {15'd0, halted}, 16'd1);
    chk("t5_busy", {15'd0, busy}, 16'd0);
    chk("t5_valid", {15'd0, out_valid}, 16'd1);
    chk("t5_head", {8'd0, out_pc}, 16'h0040);
    chk("t5_imem", {8'd0, imem_pc}, 16'h0044);
    out_ready = 1'b1; start = 1'b1;
    step;
    start = 1'b0;
    chk("t5_start_ignored", {15'd0, halted}, 16'd1);
    chk("t5_drain1", {8'd0, out_pc}, 16'h0042);
    step;
    chk("t5_drained", {15'd0, out_valid}, 16'd0);
    chk("t5_halt_hold", {15'd0, halted}, 16'd1);
    chk("t5_no_push", {8'd0, imem_pc}, 16'h0044);
    start = 1'b1;
    step;
    start = 1'b0;
    chk("t5_restart_busy", {15'd0, busy}, 16'd1);
    chk("t5_restart_pc", {8'd0, imem_pc}, 16'h0000);

    // Odd redirect together with halt_req
    redirect_valid = 1'b1; redirect_pc = 8'h51; halt_req = 1'b1;
    step;
    redirect_valid = 1'b0; halt_req = 1'b0;
    chk("t6_halted", {15'd0, halted}, 16'd1);
    chk("t6_flush", {15'd0, out_valid}, 16'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("t6_pc_kept", {8'd0, imem_pc}, 16'h0000);
    chk("t6_fault", {15'd0, align_fault}, 16'd1);
`else
    chk("t6_pc_even", {8'd0, imem_pc}, 16'h0050);
`endif
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    step;
    redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("t6_halt_redir", {8'd0, imem_pc}, 16'h0000);
    chk("t6_fault_sticky", {15'd0, align_fault}, 16'd1);
`else
    chk("t6_halt_redir", {8'd0, imem_pc}, 16'h0050);
`endif

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("ar_halted", {15'd0, halted}, 16'd0);
    chk("ar_busy", {15'd0, busy}, 16'd0);
    chk("ar_valid", {15'd0, out_valid}, 16'd0);
    chk("ar_imem", {8'd0, imem_pc}, 16'h0000);
    chk("ar_pc", {8'd0, out_pc}, 16'h0000);
    chk("ar_inst", out_inst, 16'h0000);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("ar_fault", {15'd0, align_fault}, 16'd0);
`endif
    rst = 1'b0;

    // IDLE: halt_req ignored, redirect loads the PC only
    halt_req = 1'b1;
    step;
    halt_req = 1'b0;
    chk("idle_halt_ign", {15'd0, halted}, 16'd0);
    chk("idle_busy", {15'd0, busy}, 16'd0);
    redirect_valid = 1'b1; redirect_pc = 8'h30;
    step;
    redirect_valid = 1'b0;
    chk("idle_redir", {8'd0, imem_pc}, 16'h0030);
    chk("idle_redir_busy", {15'd0, busy}, 16'd0);
    start = 1'b1;
    step;
    start = 1'b0;
    chk("idle_start", {15'd0, busy}, 16'd1);
    step;
    chk("idle_first_v", {15'd0, out_valid}, 16'd1);
    chk("idle_first_pc", {8'd0, out_pc}, 16'h0030);
    chk("idle_first_inst", out_inst, 16'h1800);

    // PC wrap on the second instance
    w_start = 1'b1;
    step;
    w_start = 1'b0;
    exp_pc = 8'hFC; n = 0; done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (w_out_valid) begin
        chk("t4_pc", {8'd0, w_out_pc}, {8'd0, exp_pc});
        chk("t4_inst", w_out_inst, exp_inst(exp_pc));
        exp_pc = exp_pc + 8'd2;
        n++;
      end
      if (w_halted && !w_out_valid) begin
        done = 1'b1;
        break;
      end
      step;
    end
    chk("t4_done", {15'd0, done}, 16'd1);
    chk("t4_count", 16'(n), 16'd4);
    chk("t4_imem_end", {8'd0, w_imem_pc}, 16'h0004);
    chk("t4_busy_end", {15'd0, w_busy}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
